// File: rtl/reset_pkg.sv
// Shared definitions for the reset request block: reset cause codes and FSM encoding.
package reset_pkg;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_BTN  = 2'b01;
  localparam logic [1:0] CAUSE_LOCK = 2'b10;

  typedef enum logic [1:0] {
    ST_HOLD = 2'b00,
    ST_WAIT = 2'b01,
    ST_RUN  = 2'b10
  } rst_state_e;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a debounce filter: the output follows the
// synchronized input only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module sync_debounce #(
  parameter int   DEBOUNCE_CYCLES = 270000,
  parameter logic RST_VAL         = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_i,
  output logic db_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q, sync_q, db_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_d;

  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      db_q   <= RST_VAL;
      cnt_q  <= '0;
    end else begin
      meta_q <= in_i;
      sync_q <= meta_q;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/reset_request.sv
// Reset request generator: combines debounced push-button and filtered PLL lock,
// enforces a minimum reset pulse and records why the last reset happened.
module reset_request
  import reset_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int MIN_PULSE       = 16,
  parameter int LOCK_FILTER     = 1024
) (
  input  logic       clk,
  input  logic       reset_in,
  input  logic       btn_n,
  input  logic       pll_lock,
  output logic       reset_req,
  output logic [1:0] cause
);

  localparam int LW = $clog2(LOCK_FILTER + 1);
  localparam int PW = $clog2(MIN_PULSE + 1);
  localparam logic [LW-1:0] LOCK_MAX   = LW'(LOCK_FILTER);
  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_FILTER - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(MIN_PULSE - 1);

  logic          btn_db;
  logic          lock_meta_q, lock_s_q;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          lock_ok_q, lock_ok_d;
  rst_state_e    state_q;
  logic [PW-1:0] pulse_cnt_q;
  logic          req_q;
  logic [1:0]    cause_q;

  sync_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RST_VAL         (1'b1)
  ) u_btn_db (
    .clk_i (clk),
    .rst_i (reset_in),
    .in_i  (btn_n),
    .db_o  (btn_db)
  );

  // Lock is accepted only after LOCK_FILTER consecutive high samples; any low drops it at once.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    lock_ok_d  = lock_ok_q;
    if (!lock_s_q) begin
      lock_cnt_d = '0;
      lock_ok_d  = 1'b0;
    end else begin
      if (lock_cnt_q != LOCK_MAX) lock_cnt_d = lock_cnt_q + 1'b1;
      if (lock_cnt_q >= LOCK_LAST) lock_ok_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      lock_cnt_q  <= '0;
      lock_ok_q   <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
      lock_cnt_q  <= lock_cnt_d;
      lock_ok_q   <= lock_ok_d;
    end
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= ST_HOLD;
      pulse_cnt_q <= '0;
      req_q       <= 1'b1;
      cause_q     <= CAUSE_POR;
    end else begin
      case (state_q)
        ST_HOLD: begin
          req_q <= 1'b1;
          if (pulse_cnt_q == PULSE_LAST) begin
            state_q     <= ST_WAIT;
            pulse_cnt_q <= '0;
          end else begin
            pulse_cnt_q <= pulse_cnt_q + 1'b1;
          end
        end
        ST_WAIT: begin
          if (lock_ok_q && btn_db) begin
            state_q <= ST_RUN;
            req_q   <= 1'b0;
          end
        end
        ST_RUN: begin
          // Lock loss takes priority over a simultaneous button press.
          if (!lock_ok_q) begin
            state_q <= ST_HOLD;
            req_q   <= 1'b1;
            cause_q <= CAUSE_LOCK;
          end else if (!btn_db) begin
            state_q <= ST_HOLD;
            req_q   <= 1'b1;
            cause_q <= CAUSE_BTN;
          end
        end
        default: begin
          state_q     <= ST_HOLD;
          pulse_cnt_q <= '0;
          req_q       <= 1'b1;
        end
      endcase
    end
  end

  assign reset_req = req_q;
  assign cause     = cause_q;

endmodule
